dmem_responder: RTL and testbench

//  Memory-side responder for data-memory requests issued by the MEM pipeline stage.

---
 rtl/dmem_responder_pkg.sv | 11 +
 rtl/dmem_responder_array.sv | 25 ++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state codes and counter width.
package dmem_responder_pkg;

  localparam int WAIT_CNT_W = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port synchronous byte RAM with write enable and a registered, read-enabled output.
module dmem_responder_array #(
  parameter int ADDRESS_LINE = 8,
  parameter int MEM_SIZE     = 256
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [ADDRESS_LINE-1:0] addr_i,
  input  logic [7:0]              wdata_i,
  output logic [7:0]              rdata_o
);

  logic [7:0] mem_q [MEM_SIZE];
  logic [7:0] rdata_q;

  // Read register only updates on re_i so the response data holds while stalled.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: accepts one load/store, waits WAIT_STATES cycles, accesses the
// byte array and holds the response until the MEM stage takes it.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDRESS_LINE = 8,
  parameter int MEM_SIZE     = 256,
  parameter int WAIT_STATES  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDRESS_LINE-1:0] req_address,
  input  logic [7:0]              req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [7:0]              rsp_rdata,
  output logic                    rsp_write,
  output logic                    rsp_error,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the sender holds
  // its payload while valid is high, and req_ready / rsp_valid never depend on the inputs.

  localparam logic [ADDRESS_LINE:0]   MEM_LIMIT = (ADDRESS_LINE + 1)'(MEM_SIZE);
  localparam logic [WAIT_CNT_W-1:0]   WAIT_INIT =
    WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic [1:0]              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDRESS_LINE-1:0] addr_q, addr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic                    rsp_write_q, rsp_write_d;
  logic                    rsp_error_q, rsp_error_d;
  logic                    in_range;
  logic                    mem_we, mem_re;
  logic [7:0]              mem_rdata;

  assign in_range = ({1'b0, addr_q} < MEM_LIMIT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_write_d = rsp_write_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_address;
          wdata_d = req_wdata;
          if (WAIT_STATES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ACCESS: begin
        rsp_write_d = wr_q;
        rsp_error_d = ~in_range;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_write_d = 1'b0;
          rsp_error_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_write_q <= rsp_write_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Out-of-range accesses never touch the array.
  assign mem_we = (state_q == ACCESS) && wr_q && in_range;
  assign mem_re = (state_q == ACCESS) && !wr_q && in_range;

  dmem_responder_array #(
    .ADDRESS_LINE(ADDRESS_LINE),
    .MEM_SIZE    (MEM_SIZE)
  ) u_array (
    .clk_i  (clock),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .addr_i (addr_q),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  // The RAM read register has no reset, so load data is qualified by a live load response.
  assign rsp_rdata = ((state_q == RESP) && !rsp_write_q && !rsp_error_q) ? mem_rdata : 8'h00;
  assign rsp_valid = (state_q == RESP);
  assign rsp_write = rsp_write_q;
  assign rsp_error = rsp_error_q;
  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with WAIT_STATES=2/MEM_SIZE=200, one with
// WAIT_STATES=0/MEM_SIZE=256, checked against a byte-array model of memory contents.
module tb_dmem_responder;

  logic       clock;
  logic       rst_n       [2];
  logic       req_valid   [2];
  logic       req_ready   [2];
  logic       req_write   [2];
  logic [7:0] req_address [2];
  logic [7:0] req_wdata   [2];
  logic       rsp_valid   [2];
  logic       rsp_ready   [2];
  logic [7:0] rsp_rdata   [2];
  logic       rsp_write   [2];
  logic       rsp_error   [2];
  logic       busy        [2];
  logic [1:0] dbg_state   [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ref_mem [2][256];
  bit         written [2][256];

  dmem_responder #(.ADDRESS_LINE(8), .MEM_SIZE(200), .WAIT_STATES(2)) u_ws2 (
    .clock(clock), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_address(req_address[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_write(rsp_write[0]), .rsp_error(rsp_error[0]), .busy(busy[0]),
    .dbg_state(dbg_state[0])
  );

  dmem_responder #(.ADDRESS_LINE(8), .MEM_SIZE(256), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_address(req_address[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_write(rsp_write[1]), .rsp_error(rsp_error[1]), .busy(busy[1]),
    .dbg_state(dbg_state[1])
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int ms_of(input int d);
    return (d == 0) ? 200 : 256;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_req_ready"}, req_ready[d], 1);
    check({tag, "_busy"},      busy[d],      0);
    check({tag, "_rsp_valid"}, rsp_valid[d], 0);
    check({tag, "_rsp_rdata"}, rsp_rdata[d], 0);
    check({tag, "_rsp_write"}, rsp_write[d], 0);
    check({tag, "_rsp_error"}, rsp_error[d], 0);
  endtask

  // ---------------- driver tasks ----------------
  // Presents a request at a negedge while the responder is idle; it is accepted at the next posedge.
  task automatic start_req(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] wd);
    int guard;
    guard = 0;
    while (!req_ready[d] && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check("req_ready_before_accept", req_ready[d], 1);
    req_valid[d]   = 1'b1;
    req_write[d]   = wr;
    req_address[d] = addr;
    req_wdata[d]   = wd;
    @(negedge clock);
    // Garbage after accept must not matter.
    req_valid[d]   = 1'b0;
    req_write[d]   = 1'($urandom);
    req_address[d] = 8'($urandom);
    req_wdata[d]   = 8'($urandom);
  endtask

  task automatic pulse_reset(input int d, input string tag);
    rst_n[d] = 1'b0;
    #1;
    check_idle(d, {tag, "_in_reset"});
    check({tag, "_state"}, dbg_state[d], 0);
    @(negedge clock);
    rst_n[d] = 1'b1;
    check_idle(d, {tag, "_after_reset"});
  endtask

  task automatic txn(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                     input int hold, input bit intrude);
    bit         exp_err;
    logic [7:0] exp_rd;
    int         lat;
    exp_err = (int'(addr) >= ms_of(d));
    exp_rd  = (wr || exp_err) ? 8'h00 : ref_mem[d][addr];
    if (wr && !exp_err) begin
      ref_mem[d][addr] = wd;
      written[d][addr] = 1'b1;
    end
    rsp_ready[d] = (hold == 0);
    start_req(d, wr, addr, wd);
    lat = 1;
    while (!rsp_valid[d] && lat < 50) begin
      check("busy_before_rsp", busy[d], 1);
      @(negedge clock);
      lat++;
    end
    check("latency", lat, ws_of(d) + 2);
    check("rsp_rdata", rsp_rdata[d], exp_rd);
    check("rsp_write", rsp_write[d], wr);
    check("rsp_error", rsp_error[d], exp_err);
    check("busy_in_rsp", busy[d], 1);
    for (int i = 0; i < hold; i++) begin
      if (intrude) begin
        req_valid[d]   = 1'b1;
        req_write[d]   = 1'b1;
        req_address[d] = 8'h50;
        req_wdata[d]   = 8'hEE;
      end
      @(negedge clock);
      check("hold_rsp_valid", rsp_valid[d], 1);
      check("hold_rsp_rdata", rsp_rdata[d], exp_rd);
      check("hold_req_ready", req_ready[d], 0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    if (hold > 0) @(negedge clock);
    @(negedge clock);
    check("rsp_done_valid", rsp_valid[d], 0);
    check("rsp_done_ready", req_ready[d], 1);
    rsp_ready[d] = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int  d;
    bit  wr;
    logic [7:0] addr;
    logic [7:0] wd;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_address[k] = 8'h00; req_wdata[k] = 8'h00; rsp_ready[k] = 1'b0;
    end
    #1;
    check_idle(0, "reset_ws2");
    check_idle(1, "reset_ws0");
    repeat (2) @(negedge clock);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clock);

    // Store then load through the two-wait-state instance.
    txn(0, 1'b1, 8'h10, 8'hA5, 0, 1'b0);
    txn(0, 1'b0, 8'h10, 8'h00, 0, 1'b0);

    // Zero wait states: busy for exactly ACCESS and RESP.
    txn(1, 1'b1, 8'h10, 8'h3C, 0, 1'b0);
    txn(1, 1'b0, 8'h10, 8'h00, 0, 1'b0);
    txn(1, 1'b1, 8'hFF, 8'hC3, 0, 1'b0);
    txn(1, 1'b0, 8'hFF, 8'h00, 2, 1'b0);

    // Back-pressure with an intruding store to 0x50 that must be ignored.
    txn(0, 1'b1, 8'h50, 8'h44, 0, 1'b0);
    txn(0, 1'b0, 8'h50, 8'h00, 5, 1'b1);
    txn(0, 1'b0, 8'h50, 8'h00, 0, 1'b0);

    // Address boundary on MEM_SIZE=200.
    txn(0, 1'b1, 8'hC7, 8'h5A, 0, 1'b0);
    txn(0, 1'b1, 8'hC8, 8'h33, 0, 1'b0);
    txn(0, 1'b0, 8'hC8, 8'h00, 1, 1'b0);
    txn(0, 1'b0, 8'hC7, 8'h00, 0, 1'b0);

    // Reset during WAIT of a store: the old value survives.
    txn(0, 1'b1, 8'h20, 8'h11, 0, 1'b0);
    start_req(0, 1'b1, 8'h20, 8'h77);
    check("mid_wait_busy", busy[0], 1);
    pulse_reset(0, "rst_wait");
    txn(0, 1'b0, 8'h20, 8'h00, 0, 1'b0);

    // Reset during RESP of a store: the write already happened.
    start_req(0, 1'b1, 8'h21, 8'h99);
    repeat (3) @(negedge clock);
    check("mid_resp_valid", rsp_valid[0], 1);
    ref_mem[0][8'h21] = 8'h99;
    written[0][8'h21] = 1'b1;
    pulse_reset(0, "rst_resp");
    txn(0, 1'b0, 8'h21, 8'h00, 0, 1'b0);

    // Randomized traffic on both instances.
    for (int i = 0; i < 60; i++) begin
      d    = int'($urandom_range(1, 0));
      wr   = 1'($urandom_range(1, 0));
      addr = 8'($urandom_range(255, 0));
      wd   = 8'($urandom);
      if (!wr && int'(addr) < ms_of(d) && !written[d][addr]) wr = 1'b1;
      txn(d, wr, addr, wd, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
